// File: rtl/lut_interp_reader_pkg.sv
// Shared widths, saturation limits and the clamp helper for the LUT interpolating reader.
package lut_interp_reader_pkg;

  localparam int ADDR_W = 4;
  localparam int FRAC_W = 4;
  localparam int DATA_W = 8;
  localparam int IN_W   = ADDR_W + FRAC_W;
  // (next - base) is DATA_W+1 bits, times an unsigned FRAC_W fraction kept signed.
  localparam int PROD_W = DATA_W + FRAC_W + 2;
  // One extra bit so base + shifted product can never overflow before clamping.
  localparam int SUM_W  = PROD_W + 1;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Clamp a wide signed sum into the signed DATA_W output range.
  function automatic logic signed [DATA_W-1:0] sat_to_data(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    hi = {{(SUM_W-DATA_W){1'b0}}, SAT_MAX};
    lo = {{(SUM_W-DATA_W){1'b1}}, SAT_MIN};
    if (v > hi)
      return SAT_MAX;
    else if (v < lo)
      return SAT_MIN;
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/lut_interp_mac.sv
// Combinational interpolation arithmetic: slope times fraction, then shift, add and clamp.
// The caller registers prod between the two halves.
module lut_interp_mac
  import lut_interp_reader_pkg::*;
(
  input  logic signed [DATA_W-1:0] base,
  input  logic signed [DATA_W-1:0] next_data,
  input  logic        [FRAC_W-1:0] frac,
  output logic signed [PROD_W-1:0] prod,
  input  logic signed [DATA_W-1:0] acc_base,
  input  logic signed [PROD_W-1:0] acc_prod,
  output logic signed [DATA_W-1:0] y
);

  logic signed [DATA_W:0]    diff;
  logic signed [FRAC_W:0]    frac_s;
  logic signed [SUM_W-1:0]   shifted;
  logic signed [SUM_W-1:0]   sum;

  // Segment slope scaled by the fraction; the fraction is zero-extended so it stays positive.
  always_comb begin
    diff   = {next_data[DATA_W-1], next_data} - {base[DATA_W-1], base};
    frac_s = {1'b0, frac};
    prod   = PROD_W'(diff) * PROD_W'(frac_s);
  end

  // Arithmetic shift floors toward -inf, then the sum is clamped to the output range.
  always_comb begin
    shifted = SUM_W'(acc_prod >>> FRAC_W);
    sum     = shifted + SUM_W'(acc_base);
    y       = sat_to_data(sum);
  end

endmodule

// File: rtl/lut_interp_reader.sv
// Three-stage streaming reader: address the LUT, form the scaled slope, then add and clamp.
// Every stage moves together on adv, so back-pressure freezes the whole pipe.
module lut_interp_reader
  import lut_interp_reader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic        [IN_W-1:0]   in_x,
  output logic        [ADDR_W-1:0] lut_addr,
  input  logic signed [DATA_W-1:0] lut_base,
  input  logic signed [DATA_W-1:0] lut_next,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_y
);

  logic                     adv;
  logic        [FRAC_W-1:0] frac1;
  logic                     v1;
  logic signed [PROD_W-1:0] prod2;
  logic signed [DATA_W-1:0] base2;
  logic                     v2;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [DATA_W-1:0] y_c;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  lut_interp_mac u_mac (
    .base      (lut_base),
    .next_data (lut_next),
    .frac      (frac1),
    .prod      (prod_c),
    .acc_base  (base2),
    .acc_prod  (prod2),
    .y         (y_c)
  );

  // S1: split the sample into LUT address and fraction.
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_addr <= '0;
      frac1    <= '0;
      v1       <= 1'b0;
    end else if (adv) begin
      lut_addr <= in_x[IN_W-1:FRAC_W];
      frac1    <= in_x[FRAC_W-1:0];
      v1       <= in_valid;
    end
  end

  // S2: capture the LUT pair as base and scaled slope.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod2 <= '0;
      base2 <= '0;
      v2    <= 1'b0;
    end else if (adv) begin
      prod2 <= prod_c;
      base2 <= lut_base;
      v2    <= v1;
    end
  end

  // S3: publish the clamped result; out_y only moves when a real sample arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2)
        out_y <= y_c;
    end
  end

endmodule

// File: tb/tb_lut_interp_reader.sv
// Self-checking bench for lut_interp_reader with a behavioural LUT and a scoreboard queue.
module tb_lut_interp_reader;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic        [7:0] in_x;
  logic        [3:0] lut_addr;
  logic signed [7:0] lut_base;
  logic signed [7:0] lut_next;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_y;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic signed [7:0] exp_q[$];
  int                exp_t[$];
  logic signed [7:0] got_q[$];
  int                got_t[$];

  lut_interp_reader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .lut_addr  (lut_addr),
    .lut_base  (lut_base),
    .lut_next  (lut_next),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lut_val(int i);
    case (i)
      0:                return 0;
      1:                return 12;
      2, 3, 4, 5, 6, 7: return 15;
      15:               return -12;
      default:          return -15;
    endcase
  endfunction

  function automatic int next_val(int i);
    if (i == 15) return lut_val(0);
    if (i == 7)  return lut_val(7);
    return lut_val(i + 1);
  endfunction

  // Behavioural LUT wired to the reader.
  always_comb begin
    lut_base = 8'(lut_val(int'(lut_addr)));
    lut_next = 8'(next_val(int'(lut_addr)));
  end

  function automatic logic signed [7:0] model_y(logic [7:0] x);
    int idx = int'(x[7:4]);
    int f   = int'(x[3:0]);
    int b   = lut_val(idx);
    int n   = next_val(idx);
    int p   = (n - b) * f;
    int q   = (p >= 0) ? (p / 16) : -((-p + 15) / 16);
    int y   = b + q;
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return 8'(y);
  endfunction

  task automatic step();
    #1;
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(model_y(in_x));
      exp_t.push_back(cyc);
    end
    if (!rst && out_valid && out_ready) begin
      got_q.push_back(out_y);
      got_t.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_list(input logic [7:0] xs[$]);
    out_ready = 1'b1;
    foreach (xs[i]) begin
      in_valid = 1'b1;
      in_x     = xs[i];
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++)
      step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_x = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_y !== 8'sd0) begin errors++; $display("[TB] FAIL reset_out_y got %0d want 0", out_y); end
    checks++; if (lut_addr !== 4'd0) begin errors++; $display("[TB] FAIL reset_lut_addr got %0d want 0", lut_addr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] xs[$];
    logic signed [7:0] e, g;
    int et, gt;
    xs = {8'h18};
    drive_list(xs);
    xs = {8'h08};
    drive_list(xs);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); et = exp_t.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("[TB] FAIL basic_missing got none want %0d", e);
      end else begin
        g = got_q.pop_front(); gt = got_t.pop_front();
        if (g !== e) begin errors++; $display("[TB] FAIL basic_value got %0d want %0d", g, e); end
        checks++;
        if (gt - et !== 3) begin errors++; $display("[TB] FAIL basic_latency got %0d want 3", gt - et); end
      end
    end
  endtask

  task automatic test_wrap_hold();
    logic [7:0] xs[$];
    logic signed [7:0] e, g;
    xs = {8'hF8, 8'h7F};
    drive_list(xs);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); void'(exp_t.pop_front());
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("[TB] FAIL wrap_hold_missing got none want %0d", e);
      end else begin
        g = got_q.pop_front(); void'(got_t.pop_front());
        if (g !== e) begin errors++; $display("[TB] FAIL wrap_hold_value got %0d want %0d", g, e); end
      end
    end
  endtask

  task automatic test_flat_frac0();
    logic [7:0] xs[$];
    logic signed [7:0] e, g;
    xs = {8'h87, 8'h10};
    drive_list(xs);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); void'(exp_t.pop_front());
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("[TB] FAIL flat_frac0_missing got none want %0d", e);
      end else begin
        g = got_q.pop_front(); void'(got_t.pop_front());
        if (g !== e) begin errors++; $display("[TB] FAIL flat_frac0_value got %0d want %0d", g, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] xs[$];
    logic signed [7:0] e, g;
    int et, gt;
    for (int i = 0; i < 16; i++)
      xs.push_back(8'($urandom_range(0, 255)));
    drive_list(xs);
    checks++;
    if (got_q.size() != 16) begin errors++; $display("[TB] FAIL b2b_count got %0d want 16", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); et = exp_t.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("[TB] FAIL b2b_missing got none want %0d", e);
      end else begin
        g = got_q.pop_front(); gt = got_t.pop_front();
        if (g !== e) begin errors++; $display("[TB] FAIL b2b_value got %0d want %0d", g, e); end
        checks++;
        if (gt - et !== 3) begin errors++; $display("[TB] FAIL b2b_latency got %0d want 3", gt - et); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] xs[6];
    logic signed [7:0] e, g, held;
    int n;
    xs = '{8'h18, 8'h08, 8'hF8, 8'h13, 8'hE5, 8'h2A};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_x = xs[i];
      step();
    end
    held = model_y(xs[0]);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_x = xs[3] ^ 8'(k);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready got %0b want 0", in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid got %0b want 1", out_valid); end
      checks++; if (out_y !== held) begin errors++; $display("[TB] FAIL bp_out_y got %0d want %0d", out_y, held); end
      step();
    end
    out_ready = 1'b1;
    for (int i = 3; i < 6; i++) begin
      in_valid = 1'b1; in_x = xs[i];
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++)
      step();
    n = got_q.size();
    checks++;
    if (n != 6) begin errors++; $display("[TB] FAIL bp_count got %0d want 6", n); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); void'(exp_t.pop_front());
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("[TB] FAIL bp_missing got none want %0d", e);
      end else begin
        g = got_q.pop_front(); void'(got_t.pop_front());
        if (g !== e) begin errors++; $display("[TB] FAIL bp_value got %0d want %0d", g, e); end
      end
    end
    got_q.delete(); got_t.delete();
  endtask

  task automatic test_reset_inflight();
    logic [7:0] xs[3];
    xs = '{8'h18, 8'h7F, 8'h87};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_x = xs[i];
      step();
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_flight_out_valid got %0b want 0", out_valid); end
    checks++; if (out_y !== 8'sd0) begin errors++; $display("[TB] FAIL rst_flight_out_y got %0d want 0", out_y); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_flight_in_ready got %0b want 1", in_ready); end
    exp_q.delete(); exp_t.delete();
    out_ready = 1'b1;
    repeat (8) step();
    checks++;
    if (got_q.size() != 0) begin errors++; $display("[TB] FAIL rst_flight_ghost got %0d outputs want 0", got_q.size()); end
    got_q.delete(); got_t.delete();
  endtask

  initial begin
    $display("[TB] lut_interp_reader bench start");
    test_reset();
    test_basic();
    test_wrap_hold();
    test_flat_frac0();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
